// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, carrier direction constants and
// carrier state type for the three-phase PWM generator.
package pwm_pkg;

    localparam int CNT_W_DEF = 12;
    localparam int DT_W_DEF  = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        ST_DOWN = DIR_DOWN,
        ST_UP   = DIR_UP
    } carrier_st_e;

endpackage

// File: rtl/pwm_carrier_gen_deadtime.sv
// pwm_deadtime: per-phase complementary gate driver with
// dead-time insertion; any raw edge restarts the interval.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            global_rst,
    input  logic            raw,
    input  logic [DT_W-1:0] dead_time,
    input  logic            pwm_en,
    output logic            h,
    output logic            l
);

    logic            raw_q, raw_d;
    logic            en_q, en_d;
    logic            h_q, h_d;
    logic            l_q, l_d;
    logic [DT_W-1:0] dt_q, dt_d;
    logic            edge_s;

    // Edge detect, dead interval countdown and side selection
    always_comb begin
        raw_d  = raw & pwm_en;
        en_d   = pwm_en;
        h_d    = h_q;
        l_d    = l_q;
        dt_d   = dt_q;
        edge_s = (raw_d != raw_q) | ~en_q;
        if (!pwm_en) begin
            h_d  = 1'b0;
            l_d  = 1'b0;
            dt_d = '0;
        end else if (edge_s) begin
            h_d = 1'b0;
            l_d = 1'b0;
            if (dead_time == '0) begin
                h_d = raw_d;
                l_d = ~raw_d;
            end else begin
                dt_d = dead_time;
            end
        end else if (dt_q != '0) begin
            dt_d = dt_q - DT_W'(1);
            if (dt_q == DT_W'(1)) begin
                h_d = raw_q;
                l_d = ~raw_q;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            raw_q <= 1'b0;
            en_q  <= 1'b0;
            h_q   <= 1'b0;
            l_q   <= 1'b0;
            dt_q  <= '0;
        end else begin
            raw_q <= raw_d;
            en_q  <= en_d;
            h_q   <= h_d;
            l_q   <= l_d;
            dt_q  <= dt_d;
        end
    end

    assign h = h_q;
    assign l = l_q;

endmodule

// File: rtl/pwm_carrier_gen.sv
// pwm_carrier_gen: center-aligned three-phase PWM with shadow duties.
// Dead-time insertion is built only with PWM_DEADTIME_EN defined.
module pwm_carrier_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PERIOD = 1000,
    parameter int DT_W   = DT_W_DEF
) (
    input  logic             clk,
    input  logic             global_rst,
    input  logic             tick_in,
    input  logic             pwm_en,
    input  logic [CNT_W-1:0] duty_a,
    input  logic [CNT_W-1:0] duty_b,
    input  logic [CNT_W-1:0] duty_c,
    input  logic             duty_valid,
    input  logic [DT_W-1:0]  dead_time,
    output logic             duty_ack,
    output logic             pwm_ah,
    output logic             pwm_al,
    output logic             pwm_bh,
    output logic             pwm_bl,
    output logic             pwm_ch,
    output logic             pwm_cl,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_dir,
    output logic             zero_pulse
);

    localparam logic [CNT_W-1:0] PEAK = CNT_W'(PERIOD);

    logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic tick_q, tick_d;

    carrier_st_e      st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zp_q, zp_d;
    logic             ack_q, ack_d;

    logic [2:0][CNT_W-1:0] duty_in;
    logic [2:0][CNT_W-1:0] pend_q, pend_d;
    logic [2:0][CNT_W-1:0] act_q, act_d;
    logic [2:0]            raw_c;

    assign duty_in = {duty_c, duty_b, duty_a};

    // Synchronizer and registered rising-edge tick
    always_comb begin
        s1_d   = tick_in;
        s2_d   = s1_q;
        s3_d   = s2_q;
        tick_d = s2_q & ~s3_q;
    end

    // Carrier up/down state machine
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        zp_d  = 1'b0;
        if (!pwm_en) begin
            st_d  = ST_UP;
            cnt_d = '0;
        end else if (tick_q) begin
            unique case (st_q)
                ST_UP: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == PEAK) st_d = ST_DOWN;
                end
                ST_DOWN: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_d == '0) begin
                        st_d = ST_UP;
                        zp_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // Shadow duties: clamp into pending, copy at period zero
    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        ack_d  = duty_valid;
        if (duty_valid) begin
            for (int i = 0; i < 3; i++) begin
                pend_d[i] = (duty_in[i] > PEAK) ? PEAK : duty_in[i];
            end
        end
        if (!pwm_en || zp_d) act_d = pend_q;
    end

    // Raw compare against active duties
    always_comb begin
        raw_c = '0;
        for (int i = 0; i < 3; i++) begin
            raw_c[i] = pwm_en & (cnt_q < act_q[i]);
        end
    end

    // Carrier, shadow and synchronizer registers
    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            tick_q <= 1'b0;
            st_q   <= ST_UP;
            cnt_q  <= '0;
            zp_q   <= 1'b0;
            ack_q  <= 1'b0;
            pend_q <= '0;
            act_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            tick_q <= tick_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            zp_q   <= zp_d;
            ack_q  <= ack_d;
            pend_q <= pend_d;
            act_q  <= act_d;
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [2:0] h_w, l_w;

    for (genvar i = 0; i < 3; i++) begin : g_dt
        pwm_deadtime #(.DT_W(DT_W)) u_dt (
            .clk       (clk),
            .global_rst(global_rst),
            .raw       (raw_c[i]),
            .dead_time (dead_time),
            .pwm_en    (pwm_en),
            .h         (h_w[i]),
            .l         (l_w[i])
        );
    end

    assign {pwm_ch, pwm_bh, pwm_ah} = h_w;
    assign {pwm_cl, pwm_bl, pwm_al} = l_w;
`else
    logic [2:0] h_q, h_d, l_q, l_d;
    logic       unused_dt;

    assign unused_dt = ^dead_time;

    // Plain complementary drive from the raw compare
    always_comb begin
        h_d = raw_c;
        l_d = {3{pwm_en}} & ~raw_c;
    end

    // Gate registers
    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            h_q <= '0;
            l_q <= '0;
        end else begin
            h_q <= h_d;
            l_q <= l_d;
        end
    end

    assign {pwm_ch, pwm_bh, pwm_ah} = h_q;
    assign {pwm_cl, pwm_bl, pwm_al} = l_q;
`endif

    assign cnt_out    = cnt_q;
    assign cnt_dir    = st_q;
    assign duty_ack   = ack_q;
    assign zero_pulse = zp_q;

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Scoreboard bench for pwm_carrier_gen with PERIOD=4; works with
// PWM_DEADTIME_EN defined or undefined.
module tb_pwm_carrier_gen;
    import pwm_pkg::*;

    localparam int CW = 12;
    localparam int DW = 8;
    localparam int P  = 4;

    logic          clk = 1'b0;
    logic          global_rst;
    logic          tick_in;
    logic          pwm_en;
    logic [CW-1:0] duty_a, duty_b, duty_c;
    logic          duty_valid;
    logic [DW-1:0] dead_time;
    logic          duty_ack;
    logic          pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl;
    logic [CW-1:0] cnt_out;
    logic          cnt_dir;
    logic          zero_pulse;

    pwm_carrier_gen #(.CNT_W(CW), .PERIOD(P), .DT_W(DW)) dut (
        .clk       (clk),
        .global_rst(global_rst),
        .tick_in   (tick_in),
        .pwm_en    (pwm_en),
        .duty_a    (duty_a),
        .duty_b    (duty_b),
        .duty_c    (duty_c),
        .duty_valid(duty_valid),
        .dead_time (dead_time),
        .duty_ack  (duty_ack),
        .pwm_ah    (pwm_ah),
        .pwm_al    (pwm_al),
        .pwm_bh    (pwm_bh),
        .pwm_bl    (pwm_bl),
        .pwm_ch    (pwm_ch),
        .pwm_cl    (pwm_cl),
        .cnt_out   (cnt_out),
        .cnt_dir   (cnt_dir),
        .zero_pulse(zero_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] prev;
        logic [CW-1:0] cnt;
        logic          dir;
        logic          zp;
        logic [5:0]    gates;
    } exp_t;

    exp_t sb[$];

    int n_run  = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;

    int m_cnt;
    bit m_dir;
    int m_pend[3];
    int m_act[3];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] gates_now();
        return {pwm_ch, pwm_cl, pwm_bh, pwm_bl, pwm_ah, pwm_al};
    endfunction

    function automatic logic [5:0] model_gates();
        logic [5:0] g;
        for (int i = 0; i < 3; i++) begin
            g[2*i+1] = (m_cnt < m_act[i]);
            g[2*i]   = !(m_cnt < m_act[i]);
        end
        return g;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 0;
            m_act[i]  = 0;
        end
    endtask

    task automatic model_tick(output exp_t e);
        e.prev = CW'(m_cnt);
        e.zp   = 1'b0;
        if (m_dir) begin
            m_cnt++;
            if (m_cnt == P) m_dir = 1'b0;
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_dir = 1'b1;
                e.zp  = 1'b1;
                m_act = m_pend;
            end
        end
        e.cnt   = CW'(m_cnt);
        e.dir   = m_dir;
        e.gates = model_gates();
    endtask

    // One divider pulse; checks latency, carrier and gate outputs
    task automatic tick_once();
        exp_t e;
        exp_t g;
        tick_in = 1'b1;
        model_tick(e);
        sb.push_back(e);
        repeat (2) @(negedge clk);
        tick_in = 1'b0;
        @(negedge clk);
        chk("cnt_hold", cnt_out, sb[0].prev);
        @(negedge clk);
        g = sb.pop_front();
        chk("cnt", cnt_out, g.cnt);
        chk("dir", cnt_dir, g.dir);
        chk("zero", zero_pulse, g.zp);
        @(negedge clk);
        chk("zero_clr", zero_pulse, 1'b0);
        chk("gates", gates_now(), g.gates);
    endtask

    task automatic write_duty(input int a, input int b, input int c);
        duty_a     = CW'(a);
        duty_b     = CW'(b);
        duty_c     = CW'(c);
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        chk("ack", duty_ack, 1'b1);
        m_pend[0] = (a > P) ? P : a;
        m_pend[1] = (b > P) ? P : b;
        m_pend[2] = (c > P) ? P : c;
        @(negedge clk);
        chk("ack_clr", duty_ack, 1'b0);
    endtask

    // Cycle tables around the peak with duty_a=4, dead_time=3
    task automatic run_table(input bit fr);
        exp_t e;
        int   n;
        logic tin, eah, eal;
        n = fr ? 20 : 12;
        model_tick(e);
        model_tick(e);
        for (int i = 0; i < n; i++) begin
            if (fr) begin
                tin = (i < 2) || (i == 10) || (i == 11);
`ifdef PWM_DEADTIME_EN
                eah = (i < 4) || (i >= 17);
                eal = (i >= 7) && (i <= 13);
`else
                eah = (i < 4) || (i >= 14);
                eal = (i >= 4) && (i <= 13);
`endif
            end else begin
                tin = (i == 0) || (i == 2);
`ifdef PWM_DEADTIME_EN
                eah = (i < 4) || (i >= 9);
                eal = 1'b0;
`else
                eah = (i < 4) || (i >= 6);
                eal = (i == 4) || (i == 5);
`endif
            end
            tick_in = tin;
            @(negedge clk);
            chk(fr ? "dt_ah" : "gl_ah", pwm_ah, eah);
            chk(fr ? "dt_al" : "gl_al", pwm_al, eal);
        end
    endtask

    // Gate safety monitor
    always @(negedge clk) begin
        if (mon_on) begin
            chk("ovl_a", pwm_ah & pwm_al, 1'b0);
            chk("ovl_b", pwm_bh & pwm_bl, 1'b0);
            chk("ovl_c", pwm_ch & pwm_cl, 1'b0);
`ifndef PWM_DEADTIME_EN
            chk("cmp_a", pwm_al, !pwm_ah);
`endif
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        global_rst = 1'b0;
        tick_in    = 1'b0;
        pwm_en     = 1'b0;
        duty_a     = '0;
        duty_b     = '0;
        duty_c     = '0;
        duty_valid = 1'b0;
        dead_time  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_cnt", cnt_out, 0);
        chk("rst_dir", cnt_dir, 1'b1);
        chk("rst_gates", gates_now(), 0);
        chk("rst_ack", duty_ack, 1'b0);
        chk("rst_zero", zero_pulse, 1'b0);
        global_rst = 1'b1;
        repeat (2) @(negedge clk);
        pwm_en = 1'b1;
        repeat (2) @(negedge clk);
        mon_on = 1'b1;

        repeat (10) tick_once();
        write_duty(2, 9, 0);
        repeat (12) tick_once();
        write_duty(2, 0, 0);
        repeat (10) tick_once();

        write_duty(4, 0, 0);
        repeat (11) tick_once();
        dead_time = DW'(3);
        run_table(1'b0);
        repeat (6) tick_once();
        run_table(1'b1);
        dead_time = '0;

        tick_once();
        mon_on = 1'b0;
        pwm_en = 1'b0;
        @(negedge clk);
        chk("dis_gates", gates_now(), 0);
        chk("dis_cnt", cnt_out, 0);
        chk("dis_dir", cnt_dir, 1'b1);
        m_cnt = 0;
        m_dir = 1'b1;
        m_act = m_pend;
        repeat (3) @(negedge clk);
        pwm_en = 1'b1;
        @(negedge clk);
        mon_on = 1'b1;
        repeat (3) tick_once();

        mon_on     = 1'b0;
        global_rst = 1'b0;
        #1;
        chk("arst_cnt", cnt_out, 0);
        chk("arst_dir", cnt_dir, 1'b1);
        chk("arst_gates", gates_now(), 0);
        chk("arst_zero", zero_pulse, 1'b0);
        @(negedge clk);
        global_rst = 1'b1;
        model_reset();
        @(negedge clk);
        mon_on = 1'b1;
        repeat (3) tick_once();
        mon_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
